// File: rtl/cnt_cmd_seq.sv
`timescale 1ns/1ps
// Command sequencer driving an up/down counter's load_en/load/down controls.
// Commands queue in a small FIFO and replay as one-cycle loads or timed runs.
module cnt_cmd_seq #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int LENW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_load,
  input  logic                     cmd_down,
  input  logic [WIDTH-1:0]         cmd_value,
  input  logic [LENW-1:0]          cmd_len,
  output logic                     load_en,
  output logic [WIDTH-1:0]         load,
  output logic                     down,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 + WIDTH + LENW;
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      level_reg;

  state_t           state_reg;
  logic [LENW-1:0]  run_cnt_reg;
  logic             load_en_reg;
  logic [WIDTH-1:0] load_reg;
  logic             down_reg;
  logic             busy_reg;
  logic             done_reg;

  logic             push;
  logic             pop;
  logic             empty;
  logic             cmd_end;
  logic [EW-1:0]    head;
  logic             head_load;
  logic             head_down;
  logic [WIDTH-1:0] head_value;
  logic [LENW-1:0]  head_len;

  // Readiness is judged on the occupancy at the start of the cycle, so a
  // same-cycle pop never opens room for a push into a full FIFO.
  assign empty     = (level_reg == '0);
  assign cmd_ready = !rst && (level_reg != FULL_LEVEL);
  assign push      = cmd_valid && cmd_ready;
  assign cmd_end   = (state_reg == LOAD) || ((state_reg == RUN) && (run_cnt_reg == '0));
  assign pop       = !empty && ((state_reg == IDLE) || cmd_end);

  assign head = mem[rd_ptr_reg];
  assign {head_load, head_down, head_value, head_len} = head;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {cmd_load, cmd_down, cmd_value, cmd_len};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + (AW+1)'(1);
        2'b01:   level_reg <= level_reg - (AW+1)'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // A pop starts the next command on the same edge the previous one ends,
  // which is what gives back-to-back commands zero idle cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      run_cnt_reg <= '0;
      load_en_reg <= 1'b0;
      load_reg    <= '0;
      down_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else if (pop) begin
      busy_reg <= 1'b1;
      if (head_load) begin
        state_reg   <= LOAD;
        load_en_reg <= 1'b1;
        load_reg    <= head_value;
        done_reg    <= 1'b1;
      end else begin
        state_reg   <= RUN;
        load_en_reg <= 1'b0;
        down_reg    <= head_down;
        run_cnt_reg <= (head_len == '0) ? '0 : head_len - LENW'(1);
        done_reg    <= (head_len <= LENW'(1));
      end
    end else if (cmd_end || (state_reg == IDLE)) begin
      state_reg   <= IDLE;
      busy_reg    <= 1'b0;
      load_en_reg <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      run_cnt_reg <= run_cnt_reg - LENW'(1);
      done_reg    <= (run_cnt_reg == LENW'(1));
    end
  end

  assign load_en = load_en_reg;
  assign load    = load_reg;
  assign down    = down_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign level   = level_reg;

endmodule

// File: tb/tb_cnt_cmd_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for cnt_cmd_seq: accepted commands expand into per-cycle
// expected control records; a negedge monitor pops and compares them.
module tb_cnt_cmd_seq;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LENW  = 8;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_load = 1'b0;
  logic             cmd_down = 1'b0;
  logic [WIDTH-1:0] cmd_value = '0;
  logic [LENW-1:0]  cmd_len = '0;
  logic             load_en;
  logic [WIDTH-1:0] load;
  logic             down;
  logic             busy;
  logic             done;
  logic [LW-1:0]    level;

  cnt_cmd_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LENW(LENW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_load(cmd_load), .cmd_down(cmd_down),
    .cmd_value(cmd_value), .cmd_len(cmd_len),
    .load_en(load_en), .load(load), .down(down),
    .busy(busy), .done(done), .level(level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             le;
    logic [WIDTH-1:0] ld;
    logic             dn;
    logic             dne;
    logic             first;
    logic [31:0]      acc_cyc;
  } rec_t;

  rec_t             exp_q[$];
  int               n_vec = 0;
  int               n_err = 0;
  int               cyc = 0;
  int               m_level = 0;
  logic             acc_flag = 1'b0;
  logic             started = 1'b0;
  logic [WIDTH-1:0] m_load = '0;
  logic             m_down = 1'b0;
  logic [WIDTH-1:0] last_ld = '0;
  logic             last_dn = 1'b0;
  rec_t             mon_r;
  logic             mon_pop;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: a command becomes its list of per-cycle control values.
  task automatic model_cmd(input logic l, input logic d, input logic [WIDTH-1:0] v,
                           input logic [LENW-1:0] n);
    int cycles;
    if (l) begin
      exp_q.push_back('{le: 1'b1, ld: v, dn: m_down, dne: 1'b1, first: 1'b1,
                        acc_cyc: 32'(cyc + 1)});
      m_load = v;
    end else begin
      cycles = (n == 0) ? 1 : int'(n);
      for (int i = 0; i < cycles; i++) begin
        exp_q.push_back('{le: 1'b0, ld: m_load, dn: d, dne: (i == cycles - 1),
                          first: (i == 0), acc_cyc: 32'(cyc + 1)});
      end
      m_down = d;
    end
  endtask

  always @(negedge clk) begin
    if (started && !rst) begin
      mon_pop = 1'b0;
      if (busy) begin
        if (exp_q.size() == 0) begin
          chk("spurious_busy", 64'(busy), 64'd0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("exec", 64'({load_en, load, down, done}),
              64'({mon_r.le, mon_r.ld, mon_r.dn, mon_r.dne}));
          mon_pop = mon_r.first;
          last_ld = mon_r.ld;
          last_dn = mon_r.dn;
        end
      end else begin
        chk("idle_out", 64'({load_en, load, down, done}),
            64'({1'b0, last_ld, last_dn, 1'b0}));
        if (exp_q.size() != 0) chk("no_bubble", 64'(exp_q[0].acc_cyc), 64'(cyc));
      end
      m_level = m_level + int'(acc_flag) - int'(mon_pop);
      acc_flag = 1'b0;
      chk("level", 64'(level), 64'(m_level));
      chk("cmd_ready", 64'(cmd_ready), 64'(m_level != DEPTH));
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic l, input logic d, input logic [WIDTH-1:0] v,
                      input logic [LENW-1:0] n, output int tries);
    bit got;
    got = 1'b0;
    tries = 0;
    cmd_load = l; cmd_down = d; cmd_value = v; cmd_len = n; cmd_valid = 1'b1;
    for (int k = 0; k < 100 && !got; k++) begin
      @(negedge clk); #3;
      tries++;
      if (cmd_ready) begin
        model_cmd(l, d, v, n);
        acc_flag = 1'b1;
        got = 1'b1;
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    cmd_value = WIDTH'($urandom);
    cmd_len = LENW'($urandom);
    if (!got) chk("accept_timeout", 64'(cmd_ready), 64'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    if (!ok) chk("drain_timeout", 64'(busy), 64'd0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_level = 0;
    acc_flag = 1'b0;
    m_load = '0;
    m_down = 1'b0;
    last_ld = '0;
    last_dn = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    logic l, d;
    logic [LENW-1:0] n;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out", 64'({load_en, load, down, busy, done, level, cmd_ready}), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    started = 1'b1;
    #1 chk("ready_after_rst", 64'(cmd_ready), 64'd1);
    @(posedge clk); #1;

    // Single load, then load followed by a down run, then a zero-length run.
    send(1'b1, 1'b0, 4'hC, 8'd0, tries);
    wait_idle();
    send(1'b1, 1'b0, 4'h3, 8'd0, tries);
    send(1'b0, 1'b1, 4'h0, 8'd3, tries);
    wait_idle();
    send(1'b1, 1'b0, 4'hF, 8'd0, tries);
    send(1'b0, 1'b0, 4'h0, 8'd0, tries);
    wait_idle();

    // Fill the FIFO behind a long run; the fifth command must stall.
    send(1'b0, 1'b0, 4'h0, 8'd20, tries);
    send(1'b1, 1'b0, 4'h9, 8'd0, tries);
    send(1'b0, 1'b1, 4'h0, 8'd2, tries);
    send(1'b1, 1'b0, 4'h4, 8'd0, tries);
    send(1'b0, 1'b0, 4'h0, 8'd1, tries);
    chk("full_level", 64'(level), 64'(DEPTH));
    chk("full_ready", 64'(cmd_ready), 64'd0);
    send(1'b1, 1'b0, 4'hA, 8'd0, tries);
    chk("full_refused", 64'(tries > 1), 64'd1);
    wait_idle();

    // Asynchronous reset in the middle of a run with commands queued.
    send(1'b0, 1'b1, 4'h0, 8'd10, tries);
    send(1'b1, 1'b0, 4'h7, 8'd0, tries);
    send(1'b0, 1'b0, 4'h0, 8'd4, tries);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out", 64'({load_en, load, down, busy, done, level, cmd_ready}), 64'd0);
    model_reset();
    @(posedge clk); #1;
    chk("held_rst_out", 64'({load_en, load, down, busy, done, level, cmd_ready}), 64'd0);
    @(negedge clk); #1;
    rst = 1'b0;
    #1;
    chk("release_ready", 64'(cmd_ready), 64'd1);
    chk("release_level", 64'(level), 64'd0);
    @(posedge clk); #1;
    send(1'b1, 1'b0, 4'h5, 8'd0, tries);
    wait_idle();

    // Randomized command stream with occasional gaps.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 4));
      l = 1'($urandom_range(0, 1));
      d = 1'($urandom_range(0, 1));
      n = ($urandom_range(0, 9) == 0) ? LENW'($urandom_range(10, 30))
                                      : LENW'($urandom_range(0, 4));
      send(l, d, WIDTH'($urandom), n, tries);
    end
    wait_idle();
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cnt_cmd_seq.md
# cnt_cmd_seq

Command sequencer that sits directly upstream of the up/down counter and drives its `load_en`, `load` and `down` controls. Software or testbench stimulus pushes commands through a valid/ready port into a small FIFO. An FSM replays each command as either a one-cycle load or a timed run in a fixed direction. It replaces ad-hoc randomized pin wiggling with deterministic, back-to-back control sequences.

## Interface
Parameters:
- `WIDTH`, 4: counter data width; matches the counter's `WIDTH`.
- `DEPTH`, 4: command FIFO entries; power of two, minimum 2.
- `LENW`, 8: width of the run-length field.

Ports:
- `clk`, input, 1: single clock; all logic on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: FIFO can accept; equals !full.
- `cmd_load`, input, 1: 1 = LOAD command, 0 = RUN command.
- `cmd_down`, input, 1: direction for RUN; ignored for LOAD.
- `cmd_value`, input, WIDTH: load value; ignored for RUN.
- `cmd_len`, input, LENW: RUN duration in cycles; 0 is treated as 1; ignored for LOAD.
- `load_en`, output, 1: to counter `load_en`; registered.
- `load`, output, WIDTH: to counter `load`; registered.
- `down`, output, 1: to counter `down`; registered.
- `busy`, output, 1: engine executing a command.
- `done`, output, 1: one-cycle pulse in the last cycle of each command.
- `level`, output, $clog2(DEPTH)+1: FIFO occupancy.

## Operation
- FIFO write on `cmd_valid && cmd_ready`. Writes while full are dropped; `cmd_ready` is low in that case and no error is flagged.
- FSM states: IDLE, LOAD, RUN.
  - IDLE: if FIFO is non-empty, pop the head and go to LOAD or RUN per `cmd_load`.
  - LOAD: `load_en`=1 and `load`=`cmd_value` for exactly 1 cycle. `down` holds its previous value.
  - RUN: `load_en`=0 and `down`=`cmd_down` for max(`cmd_len`,1) cycles. A LENW-bit down-counter is loaded with len-1, and the state exits when it reaches 0.
  - Command end: pulse `done`. If the FIFO is non-empty, pop the next command on the same edge with no bubble; otherwise go to IDLE.
- In IDLE, `load_en`=0 and `down` keep their last values. `load` holds its last value. The counter keeps counting in the last direction, which is intended.
- `busy`=1 in LOAD and RUN, 0 in IDLE.
- Simultaneous push and pop: both occur and `level` is unchanged. A push is still refused when the FIFO was full at the start of the cycle, even if a pop happens in the same cycle.
- `level` runs 0..DEPTH. `cmd_ready` = (`level` != DEPTH) and is 0 while `rst` is asserted.
- Reset values while `rst` is high: `load_en`=0, `load`=0, `down`=0, `busy`=0, `done`=0, `level`=0, `cmd_ready`=0, FSM in IDLE, FIFO pointers at 0.
- Reset mid-command aborts the command immediately and flushes the FIFO. No `done` pulse is issued for the aborted command.

## Timing
- Accept at edge E into an empty FIFO with the engine in IDLE:
  - Pop at E+1; `load_en` or `down` is valid after E+1.
  - The counter samples at E+2, so latency is 2 cycles from accept to counter effect.
- LOAD occupies 1 cycle and RUN occupies max(len,1) cycles. `done` is high during the final cycle of the command.
- Back-to-back commands already in the FIFO execute with 0 idle cycles between them.
- After `rst` deasserts, `cmd_ready`=1 in the first cycle. The first accept can occur at the first rising edge.
- All outputs are registered except `cmd_ready`, which decodes `level` combinationally.

## Test plan
1. Reset, then push LOAD value 0xC. Required: `load_en`=1 for exactly one cycle, 2 cycles after accept, with `load`=0xC; counter reads 0xC on the next edge; `done` pulses once.
2. Push LOAD 0x3, then RUN down len 3, back-to-back. Required: `load_en` for 1 cycle, then `down`=1 for 3 cycles with no gap; `done` pulses twice; counter sequence is 3, 2, 1, 0; `busy` drops after that.
3. Push RUN up len 0 after LOAD 0xF. Required: exactly 1 RUN cycle; counter wraps 0xF to 0x0; rollover is high only while count is 0xF.
4. Hold `cmd_valid`=1 with the engine busy on RUN len 20. Required: `level` reaches 4 and `cmd_ready`=0; the 5th command is not accepted; after the next pop, `cmd_ready` returns to 1 and that command is accepted.
5. Assert `rst` during RUN cycle 2 of len 10 with 2 commands queued. Required: all outputs go to reset values asynchronously, `level`=0, and no `done` pulse is issued; after release, a new LOAD 0x5 executes normally.
6. Push and pop in the same cycle with `level`=2. Required: `level` stays 2 and command order is preserved (FIFO order).
